// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer test-pattern writer.
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RELEASE = 2'd2,
    END     = 2'd3
  } state_e;

  localparam logic [15:0] COLOR_WHITE = 16'hFFFF;
  localparam logic [15:0] COLOR_BLACK = 16'h0000;
  localparam logic [1:0]  WB_SEL_ALL  = 2'b11;

  function automatic logic [15:0] grid_color(input logic x_on, input logic y_on);
    return (x_on || y_on) ? COLOR_WHITE : COLOR_BLACK;
  endfunction

endpackage

// File: rtl/fb_xy_counter.sv
// Raster-order x/y position and linear pixel index; wraps to (0,0) after the last pixel.
module fb_xy_counter #(
  parameter int HDISP = 640,
  parameter int VDISP = 480,
  parameter int XW    = $clog2(HDISP),
  parameter int YW    = $clog2(VDISP),
  parameter int IW    = $clog2(HDISP * VDISP)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic [IW-1:0] idx_o,
  output logic          last_o
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          eol;

  assign eol    = (x_q == XW'(HDISP - 1));
  assign last_o = eol && (y_q == YW'(VDISP - 1));
  assign x_o    = x_q;
  assign y_o    = y_q;
  assign idx_o  = idx_q;

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    idx_d = idx_q;
    if (clr_i || (inc_i && last_o)) begin
      x_d   = '0;
      y_d   = '0;
      idx_d = '0;
    end else if (inc_i) begin
      idx_d = idx_q + IW'(1);
      if (eol) begin
        x_d = '0;
        y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end else begin
      idx_d = idx_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      x_q   <= '0;
      y_q   <= '0;
      idx_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/fb_writer.sv
// Wishbone master that paints a grid test pattern into the framebuffer,
// dropping cyc for one cycle every BURST writes so the vga reader can win the bus.
module fb_writer
  import fb_pkg::*;
#(
  parameter int HDISP = 640,
  parameter int VDISP = 480,
  parameter int GRID  = 16,
  parameter int BURST = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        loop,
  input  logic        wb_ack,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [1:0]  wb_sel,
  output logic [31:0] wb_adr,
  output logic [15:0] wb_dat,
  output logic        busy,
  output logic        done
);

  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);
  localparam int IW = $clog2(HDISP * VDISP);
  localparam int BW = $clog2(BURST + 1);
  localparam logic [XW-1:0] XMASK = XW'(GRID - 1);
  localparam logic [YW-1:0] YMASK = YW'(GRID - 1);
  localparam logic [XW-1:0] XLAST = XW'(HDISP - 1);
  localparam logic [BW-1:0] BLAST = BW'(BURST - 1);

  state_e        state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          cyc_q, cyc_d, busy_q, busy_d, done_q, done_d;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   dat_q, dat_d;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [IW-1:0] idx;
  logic          last, inc, clr, x_hit, y_hit;

  assign inc = (state_q == WRITE) && wb_ack;
  assign clr = (state_q == IDLE);

  fb_xy_counter #(.HDISP(HDISP), .VDISP(VDISP)) u_xy (
    .CLK    (CLK),
    .RST    (RST),
    .clr_i  (clr),
    .inc_i  (inc),
    .x_o    (x),
    .y_o    (y),
    .idx_o  (idx),
    .last_o (last)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      burst_q <= '0;
      cyc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sel_q   <= 2'b00;
      dat_q   <= COLOR_BLACK;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      cyc_q   <= cyc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = WRITE;
        else       state_d = IDLE;
      end
      WRITE: begin
        if (wb_ack && last) begin
          state_d = END;
          burst_d = '0;
        end else if (wb_ack && (burst_q == BLAST)) begin
          state_d = RELEASE;
          burst_d = '0;
        end else if (wb_ack) begin
          burst_d = burst_q + BW'(1);
        end else begin
          state_d = WRITE;
        end
      end
      RELEASE: state_d = WRITE;
      END: begin
        if (loop) state_d = WRITE;
        else      state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        burst_d = '0;
      end
    endcase
  end

  // Grid hit for the pixel the counter holds after this edge: x+1 lands on the
  // grid exactly when x's low bits are all ones, so no adder or divider is needed.
  always_comb begin
    x_hit = ((x & XMASK) == '0);
    y_hit = ((y & YMASK) == '0);
    if (inc && (x == XLAST)) begin
      x_hit = 1'b1;
      y_hit = last ? 1'b1 : ((y & YMASK) == YMASK);
    end else if (inc) begin
      x_hit = ((x & XMASK) == XMASK);
    end else begin
      x_hit = ((x & XMASK) == '0);
    end
  end

  always_comb begin
    cyc_d  = (state_d == WRITE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == END);
    sel_d  = cyc_d ? WB_SEL_ALL : 2'b00;
    dat_d  = cyc_d ? grid_color(x_hit, y_hit) : COLOR_BLACK;
  end

  assign wb_cyc = cyc_q;
  assign wb_stb = cyc_q;
  assign wb_we  = cyc_q;
  assign wb_sel = sel_q;
  assign wb_dat = dat_q;
  assign wb_adr = {{(31 - IW){1'b0}}, idx, 1'b0};
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer on an 8x4 frame, grid pitch 4, bursts of 5.
module tb_fb_writer;

  localparam int FRAME = 32;
  localparam int BURST = 5;

  logic        CLK = 1'b0;
  logic        RST, start, loop, wb_ack;
  logic        wb_cyc, wb_stb, wb_we, busy, done;
  logic [1:0]  wb_sel;
  logic [31:0] wb_adr;
  logic [15:0] wb_dat;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] seen_dat [0:31];

  fb_writer #(.HDISP(8), .VDISP(4), .GRID(4), .BURST(BURST)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .start  (start),
    .loop   (loop),
    .wb_ack (wb_ack),
    .wb_cyc (wb_cyc),
    .wb_stb (wb_stb),
    .wb_we  (wb_we),
    .wb_sel (wb_sel),
    .wb_adr (wb_adr),
    .wb_dat (wb_dat),
    .busy   (busy),
    .done   (done)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] exp_dat(input int i);
    int x;
    int y;
    x = i % 8;
    y = i / 8;
    if ((x % 4 == 0) || (y % 4 == 0)) return 16'hFFFF;
    else return 16'h0000;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Walks one frame as the wishbone slave: acks each write after 'delay' wait
  // cycles and checks every observed cycle against the expected raster order.
  task automatic frame_walk(input int delay, input bit junk_ack, input bit poke_start,
                            input int stop_after, input bit use_loop);
    int nacks;
    int waited;
    int exp_idx;
    int cycles;
    bit acked;
    bit just;
    bit finished;
    nacks = 0; waited = 0; exp_idx = 0; cycles = 0;
    acked = 1'b0; finished = 1'b0;
    while (!finished && cycles < 1000) begin
      tick();
      cycles++;
      start = 1'b0;
      just = acked;
      acked = 1'b0;
      if (just) begin
        nacks++;
        exp_idx++;
      end
      if (just && nacks == stop_after) begin
        finished = 1'b1;
      end else if (just && nacks == FRAME) begin
        vectors++;
        if (done !== 1'b1 || wb_cyc !== 1'b0 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL end_cycle: done=%b cyc=%b busy=%b, expected done=1 cyc=0 busy=1",
                   done, wb_cyc, busy);
        end
        tick();
        vectors++;
        if (use_loop) begin
          if (wb_stb !== 1'b1 || wb_adr !== 32'd0 || busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL loop_restart: stb=%b adr=%h busy=%b done=%b, expected stb=1 adr=0 busy=1 done=0",
                     wb_stb, wb_adr, busy, done);
          end
        end else begin
          if (wb_cyc !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_done: cyc=%b busy=%b done=%b, expected all 0",
                     wb_cyc, busy, done);
          end
        end
        finished = 1'b1;
      end else if (just && (nacks % BURST) == 0) begin
        vectors++;
        if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL release after ack %0d: cyc=%b stb=%b done=%b busy=%b, expected cyc=0 stb=0 done=0 busy=1",
                   nacks, wb_cyc, wb_stb, done, busy);
        end
        wb_ack = junk_ack;
      end else begin
        vectors++;
        if (wb_cyc !== 1'b1 || wb_stb !== 1'b1 || wb_we !== 1'b1 || wb_sel !== 2'b11 ||
            busy !== 1'b1 || done !== 1'b0 || wb_adr !== 32'(exp_idx * 2) ||
            wb_dat !== exp_dat(exp_idx)) begin
          miscompares++;
          $display("FAIL write idx %0d: cyc=%b stb=%b we=%b sel=%b busy=%b done=%b adr=%h dat=%h, expected 1 1 1 11 1 0 adr=%h dat=%h",
                   exp_idx, wb_cyc, wb_stb, wb_we, wb_sel, busy, done, wb_adr, wb_dat,
                   32'(exp_idx * 2), exp_dat(exp_idx));
        end
        seen_dat[exp_idx] = wb_dat;
        if (waited == delay) begin
          wb_ack = 1'b1;
          acked = 1'b1;
          waited = 0;
        end else begin
          wb_ack = 1'b0;
          waited++;
        end
        if (poke_start && nacks == 7) start = 1'b1;
      end
    end
    if (!finished) begin
      miscompares++;
      $display("FAIL frame_timeout: %0d acks seen after %0d cycles, expected frame to finish", nacks, cycles);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; start = 1'b0; loop = 1'b0; wb_ack = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    vectors++;
    if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || wb_we !== 1'b0 || wb_sel !== 2'b00 ||
        wb_adr !== 32'd0 || wb_dat !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: cyc=%b stb=%b we=%b sel=%b adr=%h dat=%h busy=%b done=%b, expected all 0",
               wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat, busy, done);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (wb_cyc !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_no_start: cyc=%b busy=%b done=%b, expected 0 0 0", wb_cyc, busy, done);
      end
    end
  endtask

  task automatic test_single_frame();
    wb_ack = 1'b1;
    start = 1'b1;
    frame_walk(0, 1'b1, 1'b0, 99, 1'b0);
    vectors++;
    if (seen_dat[0] !== 16'hFFFF || seen_dat[9] !== 16'h0000 ||
        seen_dat[12] !== 16'hFFFF || seen_dat[19] !== 16'h0000) begin
      miscompares++;
      $display("FAIL pattern_spots: (0,0)=%h (1,1)=%h (4,1)=%h (3,2)=%h, expected FFFF 0000 FFFF 0000",
               seen_dat[0], seen_dat[9], seen_dat[12], seen_dat[19]);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || wb_cyc !== 1'b0) begin
        miscompares++;
        $display("FAIL post_frame_idle: done=%b busy=%b cyc=%b, expected 0 0 0", done, busy, wb_cyc);
      end
    end
  endtask

  task automatic test_ack_wait();
    wb_ack = 1'b0;
    start = 1'b1;
    frame_walk(3, 1'b1, 1'b0, 99, 1'b0);
  endtask

  task automatic test_start_ignored_and_loop();
    wb_ack = 1'b1;
    loop = 1'b1;
    start = 1'b1;
    frame_walk(0, 1'b1, 1'b1, 99, 1'b1);
    loop = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    vectors++;
    if (wb_cyc !== 1'b0 || busy !== 1'b0 || wb_adr !== 32'd0) begin
      miscompares++;
      $display("FAIL loop_stop_reset: cyc=%b busy=%b adr=%h, expected 0 0 0", wb_cyc, busy, wb_adr);
    end
  endtask

  task automatic test_reset_mid_frame();
    wb_ack = 1'b1;
    start = 1'b1;
    frame_walk(0, 1'b1, 1'b0, 12, 1'b0);
    RST = 1'b1;
    tick();
    vectors++;
    if (wb_cyc !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || wb_adr !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_frame_reset: cyc=%b done=%b busy=%b adr=%h, expected 0 0 0 0",
               wb_cyc, done, busy, wb_adr);
    end
    RST = 1'b0;
    start = 1'b1;
    frame_walk(0, 1'b1, 1'b0, 99, 1'b0);
  endtask

  task automatic test_ignored_ack();
    wb_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (wb_cyc !== 1'b0 || busy !== 1'b0 || wb_adr !== 32'd0) begin
        miscompares++;
        $display("FAIL idle_ack: cyc=%b busy=%b adr=%h, expected 0 0 0", wb_cyc, busy, wb_adr);
      end
    end
    wb_ack = 1'b0;
    start = 1'b1;
    frame_walk(1, 1'b1, 1'b0, 99, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_ack_wait();
    test_start_ignored_and_loop();
    test_reset_mid_frame();
    test_ignored_ack();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
